// File: rtl/dbus_responder.sv
// Memory-side data-bus responder: a 64-bit scratchpad with byte-strobe
// writes, a programmable response latency and an out-of-range error flag.
module dbus_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [63:0] resp_data,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;
    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  strb_q, strb_d;
    logic [63:0] wdat_q, wdat_d;
    logic        ok_q, ok_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        go;

    logic [63:0] mem [DEPTH];

    logic [63:0] sel_addr;
    logic [7:0]  sel_strb;
    logic [63:0] off;
    logic        in_range;
    logic [AW-1:0] idx;

    // Zero-latency requests are decoded straight from the live inputs.
    always_comb begin
        sel_addr = (state_q == S_IDLE) ? req_addr : addr_q;
        sel_strb = (state_q == S_IDLE) ? req_strobe : strb_q;
        off      = sel_addr - BASE;
        in_range = (sel_addr >= BASE) && (off < SPAN);
        idx      = off[AW+2:3];
    end

    logic unused_bits;
    assign unused_bits = ^{req_size, off[63:AW+3], off[2:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        strb_d  = strb_q;
        wdat_d  = wdat_q;
        ok_d    = 1'b0;
        rdata_d = 64'd0;
        err_d   = 1'b0;
        go      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    strb_d = req_strobe;
                    wdat_d = req_data;
                    if (LATENCY == 0) begin
                        go = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                if (!req_valid) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    go = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (go) begin
            state_d = S_RESP;
            ok_d    = 1'b1;
            err_d   = !in_range;
            if (in_range && sel_strb == 8'd0) begin
                rdata_d = mem[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 64'd0;
            strb_q  <= 8'd0;
            wdat_q  <= 64'd0;
            ok_q    <= 1'b0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            wdat_q  <= wdat_d;
            ok_q    <= ok_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Stores commit at the edge closing the response cycle.
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && in_range) begin
            for (int b = 0; b < 8; b++) begin
                if (strb_q[b]) begin
                    mem[idx][b*8 +: 8] <= wdat_q[b*8 +: 8];
                end
            end
        end
    end

    assign resp_addr_ok = ok_q;
    assign resp_data_ok = ok_q;
    assign resp_data    = rdata_q;
    assign resp_err     = err_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Scoreboard bench for dbus_responder: instance 0 runs LATENCY=2,
// instance 1 runs LATENCY=0.
module tb_dbus_responder;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          t;
    } exp_t;

    localparam int M_NORM  = 0;
    localparam int M_ABORT = 1;
    localparam int M_RWAIT = 2;
    localparam int M_RRESP = 3;

    logic        clk;
    logic        reset;
    logic        rv   [2];
    logic [63:0] ra   [2];
    logic [2:0]  rsz  [2];
    logic [7:0]  rs   [2];
    logic [63:0] rd   [2];
    logic        aok  [2];
    logic        dok  [2];
    logic [63:0] rdat [2];
    logic        rerr [2];

    int   cyc;
    int   total;
    int   bad;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    dbus_responder #(.LATENCY(2)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(rv[0]), .req_addr(ra[0]), .req_size(rsz[0]),
        .req_strobe(rs[0]), .req_data(rd[0]),
        .resp_addr_ok(aok[0]), .resp_data_ok(dok[0]),
        .resp_data(rdat[0]), .resp_err(rerr[0])
    );

    dbus_responder #(.LATENCY(0)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(rv[1]), .req_addr(ra[1]), .req_size(rsz[1]),
        .req_strobe(rs[1]), .req_data(rd[1]),
        .resp_addr_ok(aok[1]), .resp_data_ok(dok[1]),
        .resp_data(rdat[1]), .resp_err(rerr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (reset && dok[0] === 1'b1) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected: got data_ok=1 want none");
            end else begin
                e0 = q0.pop_front();
                chk("a_data", rdat[0], e0.data);
                chk("a_err", 64'(rerr[0]), 64'(e0.err));
                chk("a_addr_ok", 64'(aok[0]), 64'd1);
                chk("a_latency", 64'(cyc - e0.t), 64'd3);
            end
        end
    end

    always @(negedge clk) begin
        if (reset && dok[1] === 1'b1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected: got data_ok=1 want none");
            end else begin
                e1 = q1.pop_front();
                chk("b_data", rdat[1], e1.data);
                chk("b_err", 64'(rerr[1]), 64'(e1.err));
                chk("b_addr_ok", 64'(aok[1]), 64'd1);
                chk("b_latency", 64'(cyc - e1.t), 64'd1);
            end
        end
    end

    task automatic outs_zero(input string nm);
        for (int n = 0; n < 2; n++) begin
            chk({nm, "_ok"}, 64'({aok[n], dok[n]}), 64'd0);
            chk({nm, "_data"}, rdat[n], 64'd0);
            chk({nm, "_err"}, 64'(rerr[n]), 64'd0);
        end
    endtask

    task automatic issue(input int n, input logic [63:0] a,
                         input logic [7:0] s, input logic [63:0] d,
                         input logic [63:0] ed, input logic ee,
                         input int mode);
        exp_t e;
        bit   seen;
        @(negedge clk);
        rv[n]  = 1'b1;
        ra[n]  = a;
        rs[n]  = s;
        rd[n]  = d;
        rsz[n] = 3'd3;
        if (mode == M_NORM || mode == M_RRESP) begin
            e.data = ed;
            e.err  = ee;
            e.t    = cyc;
            if (n == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        if (mode == M_ABORT || mode == M_RWAIT) begin
            @(negedge clk);
            if (mode == M_ABORT) begin
                rv[n] = 1'b0;
            end else begin
                reset = 1'b0;
                #1;
                outs_zero("rst_wait");
                rv[n] = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            repeat (6) begin
                @(negedge clk);
                chk("no_resp", 64'(dok[n]), 64'd0);
            end
        end else begin
            seen = 1'b0;
            for (int w = 0; w < 40 && !seen; w++) begin
                @(negedge clk);
                seen = dok[n];
            end
            if (!seen) begin
                total++;
                bad++;
                $display("FAIL timeout: got no data_ok want data_ok within 40");
            end else if (mode == M_RRESP) begin
                #1;
                reset = 1'b0;
                rv[n] = 1'b0;
                #1;
                outs_zero("rst_resp");
                @(negedge clk);
                reset = 1'b1;
            end else begin
                rv[n] = 1'b0;
                @(negedge clk);
                chk("one_cycle", 64'(dok[n]), 64'd0);
            end
        end
        rv[n] = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        for (int n = 0; n < 2; n++) begin
            rv[n]  = 1'b0;
            ra[n]  = 64'd0;
            rs[n]  = 8'd0;
            rd[n]  = 64'd0;
            rsz[n] = 3'd0;
        end
        repeat (3) @(negedge clk);
        outs_zero("reset");
        reset = 1'b1;

        issue(0, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788,
              64'd0, 1'b0, M_NORM);
        issue(0, 64'h8000_0010, 8'h00, 64'd0,
              64'h1122_3344_5566_7788, 1'b0, M_NORM);
        issue(0, 64'h8000_0010, 8'h0C, 64'h0000_0000_AABB_0000,
              64'd0, 1'b0, M_NORM);
        issue(0, 64'h8000_0013, 8'h00, 64'd0,
              64'h1122_3344_AABB_7788, 1'b0, M_NORM);
        issue(0, 64'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF,
              64'd0, 1'b0, M_NORM);
        issue(0, 64'h8000_1FF8, 8'hFF, 64'hDEAD_BEEF_00C0_FFEE,
              64'd0, 1'b0, M_NORM);
        issue(0, 64'h7FFF_FFF8, 8'h00, 64'd0, 64'd0, 1'b1, M_NORM);
        issue(0, 64'h8000_2000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'd0, 1'b1, M_NORM);
        issue(0, 64'h8000_1FF8, 8'h00, 64'd0,
              64'hDEAD_BEEF_00C0_FFEE, 1'b0, M_NORM);
        issue(0, 64'h8000_0000, 8'h00, 64'd0,
              64'h0123_4567_89AB_CDEF, 1'b0, M_NORM);

        issue(0, 64'h8000_0010, 8'hFF, 64'd0, 64'd0, 1'b0, M_ABORT);
        issue(0, 64'h8000_0010, 8'h00, 64'd0,
              64'h1122_3344_AABB_7788, 1'b0, M_NORM);

        issue(0, 64'h8000_0010, 8'hFF, 64'h5555_5555_5555_5555,
              64'd0, 1'b0, M_RWAIT);
        issue(0, 64'h8000_0010, 8'h00, 64'd0,
              64'h1122_3344_AABB_7788, 1'b0, M_NORM);
        issue(0, 64'h8000_0010, 8'hFF, 64'h6666_6666_6666_6666,
              64'd0, 1'b0, M_RRESP);
        issue(0, 64'h8000_0010, 8'h00, 64'd0,
              64'h1122_3344_AABB_7788, 1'b0, M_NORM);

        issue(1, 64'h8000_0008, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0,
              64'd0, 1'b0, M_NORM);
        issue(1, 64'h8000_0008, 8'h00, 64'd0,
              64'hA5A5_5A5A_0F0F_F0F0, 1'b0, M_NORM);
        issue(1, 64'h8000_2000, 8'h00, 64'd0, 64'd0, 1'b1, M_NORM);
        issue(1, 64'h8000_000C, 8'h81, 64'hFF00_0000_0000_00FF,
              64'd0, 1'b0, M_NORM);
        issue(1, 64'h8000_0008, 8'h00, 64'd0,
              64'hFFA5_5A5A_0F0F_F0FF, 1'b0, M_NORM);

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(q0.size() + q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
